// File: rtl/disp_scan_if.sv
// disp_scan_if: register inputs, scan controls and segment/strobe outputs of the display scanner
interface disp_scan_if;
  logic [15:0] reg_0, reg_1, reg_2, reg_3, reg_4, reg_5, reg_6, reg_7;
  logic        mode;
  logic [1:0]  man_bank;
  logic        hold;
  logic [7:0]  disp_1, disp_2, disp_3, disp_4, disp_5, disp_6, disp_7, disp_8;
  logic [3:0]  selecter;
  logic [1:0]  bank;
  modport master (
    output reg_0, reg_1, reg_2, reg_3, reg_4, reg_5, reg_6, reg_7, mode, man_bank, hold,
    input  disp_1, disp_2, disp_3, disp_4, disp_5, disp_6, disp_7, disp_8, selecter, bank
  );
  modport slave (
    input  reg_0, reg_1, reg_2, reg_3, reg_4, reg_5, reg_6, reg_7, mode, man_bank, hold,
    output disp_1, disp_2, disp_3, disp_4, disp_5, disp_6, disp_7, disp_8, selecter, bank
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: round-robin/manual bank scanner that snapshots two registers per bank onto eight 7-seg digits
module disp_scan_ctrl #(
  parameter int TICK_DIV  = 166667,
  parameter int BLANK_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  disp_scan_if.slave io
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLANK_CYC) + 1;
  localparam logic [PW-1:0] PRE_END = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLK_END = BW'(BLANK_CYC - 1);
  localparam logic [0:0] SHOW = 1'b0, BLANK = 1'b1;
  localparam logic [15:0][7:0] SEG = {
    8'h8E, 8'h9E, 8'h7A, 8'h1A, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
    8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
  };
  logic [0:0]      state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [1:0]      bank_q, bank_d, nb;
  logic [3:0]      sel_q, sel_d;
  logic [7:0][7:0] disp_q, disp_d;
  logic [15:0]     hi, lo;
  assign nb = io.mode ? io.man_bank : bank_q + 2'd1;
  assign hi = nb == 2'd0 ? io.reg_0 : nb == 2'd1 ? io.reg_2 : nb == 2'd2 ? io.reg_4 : io.reg_6;
  assign lo = nb == 2'd0 ? io.reg_1 : nb == 2'd1 ? io.reg_3 : nb == 2'd2 ? io.reg_5 : io.reg_7;
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    blk_d   = blk_q;
    bank_d  = bank_q;
    sel_d   = sel_q;
    disp_d  = disp_q;
    if (state_q == SHOW) begin
      if (!io.hold) begin
        pre_d = pre_q == PRE_END ? '0 : pre_q + 1'b1;
        if (pre_q == PRE_END) begin
          state_d = BLANK;
          sel_d   = '0;
          disp_d  = '0;
        end
      end
    end else begin
      blk_d = blk_q == BLK_END ? '0 : blk_q + 1'b1;
      // mode/man_bank and the live registers are only looked at here, giving a tear-free snapshot
      if (blk_q == BLK_END) begin
        state_d = SHOW;
        bank_d  = nb;
        sel_d   = 4'b1000 >> nb;
        for (int i = 0; i < 4; i++) begin
          disp_d[i]   = SEG[hi[15-4*i -: 4]];
          disp_d[i+4] = SEG[lo[15-4*i -: 4]];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      pre_q   <= '0;
      blk_q   <= '0;
      bank_q  <= 2'd3;
      sel_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      blk_q   <= blk_d;
      bank_q  <= bank_d;
      sel_q   <= sel_d;
      disp_q  <= disp_d;
    end
  end
  assign io.selecter = sel_q;
  assign io.bank     = bank_q;
  assign io.disp_1   = disp_q[0];
  assign io.disp_2   = disp_q[1];
  assign io.disp_3   = disp_q[2];
  assign io.disp_4   = disp_q[3];
  assign io.disp_5   = disp_q[4];
  assign io.disp_6   = disp_q[5];
  assign io.disp_7   = disp_q[6];
  assign io.disp_8   = disp_q[7];
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan controller for the register-file display. It time-multiplexes the eight 16-bit processor registers onto the board's eight 7-segment digit positions as four banks of two registers, selected round-robin at a prescaled refresh rate. Each bank is snapshotted into output registers when it is shown, so the digits do not tear while it is on screen. It sits between the register file and the board pins, and replaces the static single-nibble display path.

## Interface

- TICK_DIV, 166667: clk cycles each bank is shown (50 MHz / 300 Hz); legal range ≥ 2.
- BLANK_CYC, 4: all-off cycles between banks (anti-ghosting); legal range ≥ 1.

- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- reg_0 … reg_7  in  16 each  live register values.
- mode  in  1  0 = auto round-robin; 1 = manual bank selection.
- man_bank  in  2  bank to show when mode=1.
- hold  in  1  1 = freeze the current bank and its snapshot.
- disp_1 … disp_8  out  8 each  segment patterns:
  - bits 7..1 drive segments a..g; bit 0 drives dp, always 0.
  - Active high.
- selecter  out  4  one-hot bank strobe; 0000 while blanking.
- bank  out  2  index of the bank currently shown.

## Operation

- Bank mapping:
  - Bank 0: reg_0/reg_1, selecter 1000.
  - Bank 1: reg_2/reg_3, selecter 0100.
  - Bank 2: reg_4/reg_5, selecter 0010.
  - Bank 3: reg_6/reg_7, selecter 0001.
- Digit mapping for bank k:
  - disp_1..disp_4 show reg_(2k) nibbles [15:12], [11:8], [7:4], [3:0].
  - disp_5..disp_8 show reg_(2k+1) nibbles in the same order.
- Hex decode:
  - 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0.
  - 8 FE, 9 F6, A EE, b 3E, c 1A, d 7A, E 9E, F 8E.
- FSM with two states, SHOW and BLANK.
  - Prescaler counts 0..TICK_DIV-1 in SHOW.
  - Blank counter counts 0..BLANK_CYC-1 in BLANK.
- SHOW → BLANK:
  - Taken on the edge where the prescaler is at TICK_DIV-1 and hold=0.
  - On that edge: selecter ← 0000, all disp ← 00, prescaler ← 0.
- BLANK → SHOW, taken on the edge where the blank counter is at BLANK_CYC-1. On that edge:
  - next bank = (bank+1) mod 4 when mode=0, or man_bank when mode=1.
  - bank and selecter are loaded with the next bank.
  - All eight disp registers are loaded with the decoded live values of that bank's two registers (the snapshot).
  - Blank counter ← 0.
- Snapshot rule: disp outputs change only on a BLANK→SHOW edge or a SHOW→BLANK edge (or reset). Register changes during SHOW are not visible until the next visit to that bank.
- hold:
  - Ignored in BLANK; blanking always completes.
  - In SHOW, hold=1 stalls the prescaler; bank, selecter and disp stay constant.
  - Release resumes counting from the stalled value.
- mode and man_bank are sampled only on the BLANK→SHOW edge. Mid-SHOW changes take effect at the next bank change.
- All outputs are registered; there is no combinational input-to-output path.

## Timing

- Reset, sampled on any edge with rst=1, overrides everything including mid-SHOW, mid-BLANK and hold. Results:
  - State BLANK; both counters 0.
  - bank = 3, so the first advance goes to 0.
  - selecter = 0000; disp_1..disp_8 = 00.
- First display: with rst low from edge 0, bank 0 appears on edge BLANK_CYC (mode=0).
- Steady auto period per bank is TICK_DIV + BLANK_CYC cycles. A full four-bank frame is 4·(TICK_DIV+BLANK_CYC) cycles.
- Mode=1 after reset: the first bank shown is man_bank, sampled at edge BLANK_CYC.
- Latency from reg_x change to display is at most one frame plus 0 cycles, with no pipeline stage. A value sampled on a BLANK→SHOW edge appears on the outputs on that same edge.
- Simultaneous events:
  - hold=1 at prescaler TICK_DIV-1: stall, no transition.
  - rst=1 with any other input: reset wins.
- Counter widths: $clog2(TICK_DIV) and $clog2(BLANK_CYC)+1. No wrap is possible beyond terminal counts.

## Test plan

- Reset: with TICK_DIV=4, BLANK_CYC=2, hold rst 3 cycles. Required while rst is held: selecter=0000, all disp=00, bank=3.
- Auto scan: set reg_0=0x1234, reg_1=0xABCD, reg_2..7=0x000F·k, then release rst. Required:
  - Edge 2: selecter=1000, disp_1..8 = 60 DA F2 66 EE 3E 1A 7A.
  - Edges 6–7: 0000/00.
  - Edge 8: selecter=0100.
  - Order continues 0001 → 1000.
- Snapshot: change reg_0 to 0xFFFF one cycle into bank 0 SHOW. Required: disp_1..4 stay 60 DA F2 66 until bank 0 is next shown, then read 8E ×4.
- Manual: mode=1, man_bank=2 from reset. Required: selecter=0010 on every SHOW, with blanking still between. Switching to man_bank=1 mid-SHOW takes effect only after the next BLANK.
- Hold: assert hold at prescaler=3 for 10 cycles. Required: no blank during the hold; the transition occurs on the edge after release. Also assert hold during BLANK: BLANK still ends after 2 cycles.
- Mid-operation reset: assert rst during BLANK and during SHOW of bank 2. Required: outputs 0000/00 on the next edge, and bank 0 is shown BLANK_CYC edges after release.
